// File: rtl/axis_uart_pkg.sv
// Shared constants, FSM state type and baud divider helper for the AXIS UART datapath.
package axis_uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned TUSER_FERR = 0;
  localparam int unsigned TUSER_PERR = 1;
  localparam int unsigned TUSER_W    = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  // Clocks per oversample tick; zero means the clock is too slow for the line rate.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/axis_uart_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only alongside a pop.
module axis_uart_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_uart_fifo: DEPTH must be a power of two, at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push_c;
  logic             do_pop_c;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_c  = pop && !empty_q;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    do_push_c = push && (!full_q || do_pop_c);
    if (do_push_c) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign head_data_c = mem_q[rd_ptr_q];
  assign full        = full_q;
  assign empty       = empty_q;

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver: 16x oversampled majority-vote framing into an AXI4-Stream master via a small FIFO.
module axis_uart_rx
  import axis_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic [TUSER_W-1:0]   m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 overrun
);

  localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CW     = $clog2(DIV) + 1;
  localparam int unsigned SW     = $clog2(OVERSAMPLE);
  localparam int unsigned BW     = $clog2(DATA_BITS + 1);
  localparam int unsigned FIFO_W = DATA_BITS + TUSER_W;

  if (DIV < 1) begin : g_bad_div
    $error("axis_uart_rx: CLK_FREQ too low for BAUD*OVERSAMPLE");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
    $error("axis_uart_rx: OVERSAMPLE must be even and at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("axis_uart_rx: DATA_BITS must be 5..9");
  end
  if (!(PARITY == PAR_NONE || PARITY == PAR_EVEN || PARITY == PAR_ODD)) begin : g_bad_par
    $error("axis_uart_rx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("axis_uart_rx: STOP_BITS must be 1 or 2");
  end

  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                 tick_c;
  logic                 prev_q, prev_d;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           samp_q, samp_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 vote_c;
  logic                 vote_pt_c;
  logic                 push_c;
  logic                 pop_c;
  logic [TUSER_W-1:0]   push_user_c;
  logic [FIFO_W-1:0]    push_data_c;
  logic [FIFO_W-1:0]    head_c;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Free-running oversample tick.
  always_comb begin
    tick_c     = (tick_cnt_q == CW'(DIV - 1));
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + CW'(1);
  end

  // Two earlier samples plus the current one decide the bit.
  assign vote_c    = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
  assign vote_pt_c = tick_c && (scnt_q == SW'(OVERSAMPLE / 2 + 1));
  assign pop_c     = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    scnt_d      = scnt_q;
    bitcnt_d    = bitcnt_q;
    data_d      = data_q;
    samp_d      = samp_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    push_c      = 1'b0;
    push_user_c = '0;

    if (tick_c) begin
      prev_d = sync2_q;
      scnt_d = (scnt_q == SW'(OVERSAMPLE - 1)) ? '0 : scnt_q + SW'(1);
      if (scnt_q == SW'(OVERSAMPLE / 2 - 1)) samp_d[0] = sync2_q;
      if (scnt_q == SW'(OVERSAMPLE / 2))     samp_d[1] = sync2_q;
    end

    unique case (state_q)
      S_IDLE: begin
        scnt_d = '0;
        // Only a fresh high-to-low transition starts a frame.
        if (tick_c && prev_q && !sync2_q) begin
          state_d  = S_START;
          bitcnt_d = '0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
        end
      end
      S_START: begin
        if (vote_pt_c) begin
          state_d  = vote_c ? S_IDLE : S_DATA;
          bitcnt_d = '0;
        end
      end
      S_DATA: begin
        if (vote_pt_c) begin
          data_d = {vote_c, data_q[DATA_BITS-1:1]};
          if (bitcnt_q == BW'(DATA_BITS - 1)) begin
            bitcnt_d = '0;
            state_d  = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (vote_pt_c) begin
          perr_d  = ((^data_q) ^ vote_c) != (PARITY == PAR_ODD);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (vote_pt_c) begin
          if (!vote_c) ferr_d = 1'b1;
          // Push at the last stop-bit decision instead of waiting out the bit.
          if (bitcnt_q == BW'(STOP_BITS - 1)) begin
            push_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    push_user_c[TUSER_PERR] = perr_q;
    push_user_c[TUSER_FERR] = ferr_d;
  end

  assign push_data_c = {push_user_c, data_q};
  assign overrun_d   = push_c & fifo_full & ~pop_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_cnt_q <= '0;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      scnt_q     <= '0;
      bitcnt_q   <= '0;
      data_q     <= '0;
      samp_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bitcnt_q   <= bitcnt_d;
      data_q     <= data_d;
      samp_q     <= samp_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  axis_uart_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push_c),
    .push_data   (push_data_c),
    .pop         (pop_c),
    .head_data_c (head_c),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign m_axis_tdata  = head_c[DATA_BITS-1:0];
  assign m_axis_tuser  = head_c[DATA_BITS +: TUSER_W];
  assign m_axis_tvalid = ~fifo_empty;
  assign overrun       = overrun_q;

endmodule

// File: doc/axis_uart_rx.md
# axis_uart_rx

Parametrised UART receiver with 16x oversampling, majority-vote bit sampling, optional parity, one or two stop bits, per-frame error reporting and an AXI4-Stream master output backed by a small FIFO. It is the generalised successor to the single-byte receive path. It sits between the `rx` pin and any AXI-Stream consumer in the AXIS UART datapath.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: samples per bit; even, at least 8.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: parity mode; 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: stop bits, 1 or 2.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, at least 2.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `rx` in 1: asynchronous serial input, idle high.
- `m_axis_tdata` out DATA_BITS: received data, LSB = first bit on the line.
- `m_axis_tuser` out 2: bit 1 = parity error, bit 0 = framing error.
- `m_axis_tvalid` out 1: FIFO non-empty.
- `m_axis_tready` in 1: consumer accepts.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.

## Operation
- `rx` passes through a 2-FF synchroniser before all logic.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division.
  - DIV ≥ 1 is enforced by an elaboration-time check.
  - Counter width is $clog2(DIV)+1.
  - A one-cycle `tick` fires every DIV clocks, free-running.
- All FSM and sample counters advance only on `tick`. The sample counter runs 0..OVERSAMPLE-1.
- Majority vote: bit value = majority of the synchronised samples at sample counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit decision is taken at count OVERSAMPLE/2+1.
- FSM states:
  - IDLE: on a tick where the previous sample is 1 and the current sample is 0 (falling edge), clear counters and go to START. A line held low never re-triggers; a fresh high-to-low edge is required.
  - START: at the vote point, a voted 1 is a false start → IDLE with nothing pushed. A voted 0 → DATA.
  - DATA: shift in one voted bit per bit period, LSB first. After DATA_BITS bits → PARITY if PARITY≠0, else STOP.
  - PARITY: parity error = (XOR of data ^ voted parity bit) ≠ (PARITY==2). Then → STOP.
  - STOP: each stop bit is voted; any stop bit voted 0 sets the framing error. At the vote point of the last stop bit, push {perr, ferr, data} and → IDLE. The FSM does not wait for the rest of the stop bit.
- Frames with errors are still pushed; the error status travels in `tuser`.
- FIFO:
  - Push and pop in the same cycle is legal when the FIFO is non-empty, including when full; occupancy is unchanged.
  - A push while full, with no pop in that cycle, drops the frame and pulses `overrun`. FIFO contents are unchanged.
  - A pop while empty is impossible because `tvalid` is 0.
- AXI-Stream: `tdata`/`tuser` hold the FIFO head and stay stable while `tvalid`=1 and `tready`=0. Transfer happens when tvalid&tready.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE, FIFO empty.
  - Synchroniser and previous-sample registers set to 1, so a line low at reset release is not taken as a start.
- A reset mid-frame or with a non-empty FIFO discards everything within one clock.
- Input latency: 2 clocks synchroniser, plus up to DIV clocks of tick quantisation.
- Decision points:
  - Start decision: OVERSAMPLE/2+2 ticks after the edge-detect tick.
  - Each later bit: OVERSAMPLE ticks after the previous decision.
- Push happens on the last stop-bit decision tick. `m_axis_tvalid` rises on the following clock.
- Pop: `tvalid` falls on the clock after the last entry is accepted.
- Back-to-back frames need no idle time beyond the stop bits.

## Structure
- Package `axis_uart_pkg`:
  - Parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD.
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - tuser bit indices.
  - DIV computation function.
- Sub-module `axis_uart_fifo`: synchronous FIFO, parameters WIDTH/DEPTH, with show-ahead outputs and full/empty. It is reusable for the TX side.
- Synchroniser, tick generator and FSM live in the top.

## Test plan
- Use CLK_FREQ=7_372_800, BAUD=115200, OVERSAMPLE=16 → DIV=4, bit = 64 clocks.
- 8N1, send 0xA5 with `tready`=1 → one beat: tdata=0xA5, tuser=2'b00.
- 8E1, send 0x07 with parity bit 0 (wrong; expected 1) → tdata=0x07, tuser=2'b10. 8O1 with the correct parity bit → tuser=2'b00.
- 8N2, send 0x3C with the second stop bit driven 0 → tuser=2'b01. Then hold `rx` low for 20 bit times → no further beats. Release high, send 0x11 → tdata=0x11.
- Glitch: `rx` low for 24 clocks (under half a bit) → no beat, FSM back in IDLE. A following 0x55 is received correctly.
- FIFO_DEPTH=4, `tready`=0, send 5 frames 0x01..0x05 → one `overrun` pulse at the 5th push. Then `tready`=1 → beats 0x01..0x04 in order.
- Assert `rst_n`=0 mid-DATA of 0x99 with 2 entries queued → `tvalid`=0 next clock. After release, send 0x42 → only 0x42 emerges.
